// File: rtl/hazard_sched.sv
// rtl/hazard_sched.sv - pipeline hazard scheduler: forwarding selects, load-use stalls, branch flushes
// Tracks rd of instructions in execute (E) and write (W); keeps saturating stall/flush debug counters.
module hazard_sched #(
    parameter int LOAD_STALL   = 1,
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             dec_valid,
    input  logic [4:0]       dec_rs1,
    input  logic [4:0]       dec_rs2,
    input  logic [4:0]       dec_rd,
    input  logic             dec_isLoad,
    input  logic             dec_wrRd,
    input  logic             originPc,
    output logic             stall,
    output logic             bubble_e,
    output logic             flush_d,
    output logic [1:0]       fwd_rs1,
    output logic [1:0]       fwd_rs2,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_STALL = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    localparam logic [1:0] LS_M1 = 2'(LOAD_STALL - 1);
    localparam logic [1:0] FC_M1 = 2'(FLUSH_CYCLES - 1);

    state_t           r_state;
    logic [1:0]       r_cnt;

    logic             r_e_valid;
    logic [4:0]       r_e_rd;
    logic             r_e_load;
    logic             r_e_wr;
    logic             r_w_valid;
    logic [4:0]       r_w_rd;
    logic             r_w_wr;

    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    logic             w_e_m1;
    logic             w_e_m2;
    logic             w_w_m1;
    logic             w_w_m2;
    logic             w_hazard;
    logic             w_stall;
    logic             w_flush;
    logic             w_bubble;
    logic [1:0]       w_fwd_rs1;
    logic [1:0]       w_fwd_rs2;

    // x0 is hardwired, so a zero source never matches anything in flight
    function automatic logic f_match(input logic [4:0] rs, input logic v,
                                     input logic wr, input logic [4:0] rd);
        return (rs != 5'd0) && v && wr && (rd == rs);
    endfunction

    always_comb begin
        w_e_m1 = f_match(dec_rs1, r_e_valid, r_e_wr, r_e_rd);
        w_e_m2 = f_match(dec_rs2, r_e_valid, r_e_wr, r_e_rd);
        w_w_m1 = f_match(dec_rs1, r_w_valid, r_w_wr, r_w_rd);
        w_w_m2 = f_match(dec_rs2, r_w_valid, r_w_wr, r_w_rd);

        w_fwd_rs1 = 2'd0;
        if (w_e_m1 && !r_e_load)
            w_fwd_rs1 = 2'd1;
        else if (w_w_m1)
            w_fwd_rs1 = 2'd2;

        w_fwd_rs2 = 2'd0;
        if (w_e_m2 && !r_e_load)
            w_fwd_rs2 = 2'd1;
        else if (w_w_m2)
            w_fwd_rs2 = 2'd2;

        w_hazard = dec_valid && r_e_load && (w_e_m1 || w_e_m2);

        // A taken branch squashes the dependent instruction, so it overrides any stall
        w_flush  = !reset && (originPc || (r_state == S_FLUSH));
        w_stall  = !reset && !originPc &&
                   (((r_state == S_RUN) && w_hazard) || (r_state == S_STALL));
        w_bubble = w_flush || w_stall;
    end

    assign stall     = w_stall;
    assign bubble_e  = w_bubble;
    assign flush_d   = w_flush;
    assign fwd_rs1   = w_fwd_rs1;
    assign fwd_rs2   = w_fwd_rs2;
    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_RUN;
            r_cnt       <= 2'd0;
            r_e_valid   <= 1'b0;
            r_e_rd      <= 5'd0;
            r_e_load    <= 1'b0;
            r_e_wr      <= 1'b0;
            r_w_valid   <= 1'b0;
            r_w_rd      <= 5'd0;
            r_w_wr      <= 1'b0;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            r_e_valid <= dec_valid && !w_bubble;
            r_e_rd    <= dec_rd;
            r_e_load  <= dec_isLoad;
            r_e_wr    <= dec_wrRd;
            r_w_valid <= r_e_valid;
            r_w_rd    <= r_e_rd;
            r_w_wr    <= r_e_wr;

            if (w_stall && (r_stall_cnt != '1))
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            if (originPc && (r_flush_cnt != '1))
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);

            if (originPc) begin
                if (FLUSH_CYCLES > 1) begin
                    r_state <= S_FLUSH;
                    r_cnt   <= FC_M1;
                end else begin
                    r_state <= S_RUN;
                    r_cnt   <= 2'd0;
                end
            end else begin
                case (r_state)
                    S_RUN: begin
                        if (w_hazard && (LOAD_STALL > 1)) begin
                            r_state <= S_STALL;
                            r_cnt   <= LS_M1;
                        end
                    end
                    S_STALL, S_FLUSH: begin
                        r_cnt <= r_cnt - 2'd1;
                        if (r_cnt <= 2'd1)
                            r_state <= S_RUN;
                    end
                    default: begin
                        r_state <= S_RUN;
                        r_cnt   <= 2'd0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_hazard_sched.sv
// tb/tb_hazard_sched.sv - directed bench for hazard_sched with two parameter sets sharing stimulus
// u_a: LOAD_STALL=1, FLUSH_CYCLES=2, CNT_W=16; u_b: LOAD_STALL=3, FLUSH_CYCLES=1, CNT_W=4.
module tb_hazard_sched;

    logic        clk;
    logic        reset;
    logic        dec_valid;
    logic [4:0]  dec_rs1;
    logic [4:0]  dec_rs2;
    logic [4:0]  dec_rd;
    logic        dec_isLoad;
    logic        dec_wrRd;
    logic        originPc;

    logic        a_stall, a_bubble, a_flush;
    logic [1:0]  a_fwd_rs1, a_fwd_rs2;
    logic [15:0] a_stall_cnt, a_flush_cnt;
    logic        b_stall, b_bubble, b_flush;
    logic [1:0]  b_fwd_rs1, b_fwd_rs2;
    logic [3:0]  b_stall_cnt, b_flush_cnt;

    int n_pass;
    int n_total;

    hazard_sched #(.LOAD_STALL(1), .FLUSH_CYCLES(2), .CNT_W(16)) u_a (
        .clk(clk), .reset(reset), .dec_valid(dec_valid), .dec_rs1(dec_rs1),
        .dec_rs2(dec_rs2), .dec_rd(dec_rd), .dec_isLoad(dec_isLoad),
        .dec_wrRd(dec_wrRd), .originPc(originPc), .stall(a_stall),
        .bubble_e(a_bubble), .flush_d(a_flush), .fwd_rs1(a_fwd_rs1),
        .fwd_rs2(a_fwd_rs2), .stall_cnt(a_stall_cnt), .flush_cnt(a_flush_cnt)
    );

    hazard_sched #(.LOAD_STALL(3), .FLUSH_CYCLES(1), .CNT_W(4)) u_b (
        .clk(clk), .reset(reset), .dec_valid(dec_valid), .dec_rs1(dec_rs1),
        .dec_rs2(dec_rs2), .dec_rd(dec_rd), .dec_isLoad(dec_isLoad),
        .dec_wrRd(dec_wrRd), .originPc(originPc), .stall(b_stall),
        .bubble_e(b_bubble), .flush_d(b_flush), .fwd_rs1(b_fwd_rs1),
        .fwd_rs2(b_fwd_rs2), .stall_cnt(b_stall_cnt), .flush_cnt(b_flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic drv(input int v, input int rs1, input int rs2, input int rd,
                       input int ld, input int wr, input int br);
        dec_valid  = 1'(v);
        dec_rs1    = 5'(rs1);
        dec_rs2    = 5'(rs2);
        dec_rd     = 5'(rd);
        dec_isLoad = 1'(ld);
        dec_wrRd   = 1'(wr);
        originPc   = 1'(br);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        reset   = 1'b1;
        drv(0, 0, 0, 0, 0, 0, 1);
        step();
        step();
        chk("rst_a_stall", 32'(a_stall), 0);
        chk("rst_a_bubble", 32'(a_bubble), 0);
        chk("rst_a_flush_gated", 32'(a_flush), 0);
        chk("rst_a_fwd1", 32'(a_fwd_rs1), 0);
        chk("rst_a_scnt", 32'(a_stall_cnt), 0);
        chk("rst_a_fcnt", 32'(a_flush_cnt), 0);
        drv(0, 0, 0, 0, 0, 0, 0);
        reset = 1'b0;
        step();

        // ALU back-to-back forwarding
        drv(1, 0, 0, 5, 0, 1, 0); #1;
        chk("alu_w5_fwd1", 32'(a_fwd_rs1), 0);
        step();
        drv(1, 5, 0, 6, 0, 1, 0); #1;
        chk("alu_d1_fwd1", 32'(a_fwd_rs1), 1);
        chk("alu_d1_stall", 32'(a_stall), 0);
        step();
        drv(1, 5, 6, 0, 0, 0, 0); #1;
        chk("alu_d2_fwd1", 32'(a_fwd_rs1), 2);
        chk("alu_d2_fwd2", 32'(a_fwd_rs2), 1);
        chk("alu_d2_stall", 32'(a_stall), 0);
        step();

        // x0: load to x0 then reader of x0
        drv(1, 6, 0, 0, 1, 1, 0); #1;
        chk("x0_fwd1_w", 32'(a_fwd_rs1), 2);
        step();
        drv(1, 0, 0, 7, 1, 1, 0); #1;
        chk("x0_fwd1", 32'(a_fwd_rs1), 0);
        chk("x0_a_stall", 32'(a_stall), 0);
        chk("x0_b_stall", 32'(b_stall), 0);
        step();

        // load-use on rs2 = 7
        drv(1, 0, 7, 8, 0, 1, 0); #1;
        chk("lu_a_stall", 32'(a_stall), 1);
        chk("lu_a_bubble", 32'(a_bubble), 1);
        chk("lu_a_flush", 32'(a_flush), 0);
        chk("lu_a_fwd2", 32'(a_fwd_rs2), 0);
        chk("lu_b_stall", 32'(b_stall), 1);
        step();
        #1;
        chk("lu_a_stall_rel", 32'(a_stall), 0);
        chk("lu_a_bubble_rel", 32'(a_bubble), 0);
        chk("lu_a_fwd2_w", 32'(a_fwd_rs2), 2);
        chk("lu_a_scnt", 32'(a_stall_cnt), 1);
        chk("lu_b_stall_2", 32'(b_stall), 1);
        step();
        #1;
        chk("lu_b_stall_3", 32'(b_stall), 1);
        chk("lu_a_stall_idle", 32'(a_stall), 0);
        step();
        drv(0, 0, 0, 0, 0, 0, 0); #1;
        chk("lu_b_stall_end", 32'(b_stall), 0);
        chk("lu_b_scnt", 32'(b_stall_cnt), 3);
        chk("lu_a_scnt_hold", 32'(a_stall_cnt), 1);
        step();

        // branch coinciding with a load-use hazard
        drv(1, 0, 0, 9, 1, 1, 0);
        step();
        drv(1, 9, 0, 10, 0, 1, 1); #1;
        chk("br_a_flush", 32'(a_flush), 1);
        chk("br_a_bubble", 32'(a_bubble), 1);
        chk("br_a_stall", 32'(a_stall), 0);
        chk("br_b_stall", 32'(b_stall), 0);
        step();
        drv(1, 9, 0, 10, 0, 1, 0); #1;
        chk("br2_a_flush", 32'(a_flush), 1);
        chk("br2_a_bubble", 32'(a_bubble), 1);
        chk("br2_a_stall", 32'(a_stall), 0);
        chk("br2_a_fcnt", 32'(a_flush_cnt), 1);
        chk("br2_b_fwd1", 32'(b_fwd_rs1), 2);
        chk("br2_b_flush", 32'(b_flush), 0);
        step();
        drv(0, 0, 0, 0, 0, 0, 0); #1;
        chk("br3_a_flush", 32'(a_flush), 0);
        chk("br3_a_bubble", 32'(a_bubble), 0);
        chk("br3_a_scnt", 32'(a_stall_cnt), 1);
        step();

        // second branch inside FLUSH reloads the counter
        drv(0, 0, 0, 0, 0, 0, 1);
        step();
        drv(0, 0, 0, 0, 0, 0, 1); #1;
        chk("rl_a_flush", 32'(a_flush), 1);
        step();
        drv(0, 0, 0, 0, 0, 0, 0); #1;
        chk("rl_a_flush_hold", 32'(a_flush), 1);
        step();
        #1;
        chk("rl_a_flush_end", 32'(a_flush), 0);
        chk("rl_a_fcnt", 32'(a_flush_cnt), 3);
        step();

        // branch during a LOAD_STALL=3 stall aborts it
        drv(1, 0, 0, 11, 1, 1, 0);
        step();
        drv(1, 11, 0, 12, 0, 1, 0); #1;
        chk("sb_b_stall", 32'(b_stall), 1);
        step();
        drv(1, 11, 0, 12, 0, 1, 1); #1;
        chk("sb_b_stall_rel", 32'(b_stall), 0);
        chk("sb_b_flush", 32'(b_flush), 1);
        chk("sb_b_bubble", 32'(b_bubble), 1);
        step();
        drv(0, 0, 0, 0, 0, 0, 0); #1;
        chk("sb_b_run_stall", 32'(b_stall), 0);
        chk("sb_b_run_flush", 32'(b_flush), 0);
        chk("sb_b_scnt", 32'(b_stall_cnt), 4);
        chk("sb_a_flush", 32'(a_flush), 1);
        step();
        #1;
        chk("sb_a_fcnt", 32'(a_flush_cnt), 4);
        chk("sb_b_fcnt", 32'(b_flush_cnt), 4);
        step();

        // reset in the second cycle of a LOAD_STALL=3 stall
        drv(1, 0, 0, 13, 1, 1, 0);
        step();
        drv(1, 0, 13, 14, 0, 1, 0); #1;
        chk("mr_b_stall_1", 32'(b_stall), 1);
        step();
        #1;
        chk("mr_b_stall_2", 32'(b_stall), 1);
        chk("mr_b_fwd2", 32'(b_fwd_rs2), 2);
        reset = 1'b1;
        #1;
        chk("mr_b_stall", 32'(b_stall), 0);
        chk("mr_b_bubble", 32'(b_bubble), 0);
        chk("mr_b_flush", 32'(b_flush), 0);
        chk("mr_b_fwd2_clr", 32'(b_fwd_rs2), 0);
        chk("mr_b_scnt", 32'(b_stall_cnt), 0);
        chk("mr_b_fcnt", 32'(b_flush_cnt), 0);
        chk("mr_a_scnt", 32'(a_stall_cnt), 0);
        step();
        reset = 1'b0;
        #1;
        chk("mr_b_run", 32'(b_stall), 0);
        step();
        #1;
        chk("mr_b_run_post", 32'(b_stall), 0);
        chk("mr_b_scnt_post", 32'(b_stall_cnt), 0);
        chk("mr_b_fcnt_post", 32'(b_flush_cnt), 0);

        // repeated self-dependent loads drive the counters; u_b saturates at 4'hF
        drv(1, 1, 0, 1, 1, 1, 0);
        repeat (8) step();
        chk("sat_a_scnt_8", 32'(a_stall_cnt), 4);
        chk("sat_b_scnt_8", 32'(b_stall_cnt), 6);
        repeat (32) step();
        chk("sat_a_scnt_40", 32'(a_stall_cnt), 20);
        chk("sat_b_scnt_40", 32'(b_stall_cnt), 15);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/hazard_sched.md
Name: hazard_sched

Overview:
- Pipeline hazard scheduler for the three-stage core: fetch/decode, execute and write.
- Tracks the destination registers of instructions in flight in execute and write.
- Generates the register-bank forwarding selects, load-use stalls and branch flushes.
- Replaces the ad-hoc last-rd compare in `control`. Keeps saturating stall and flush counters for debug.

Parameters:
- LOAD_STALL, 1, bubbles inserted on a load-use hazard (legal 1..3).
- FLUSH_CYCLES, 1, cycles the decode stage is killed after a taken branch (legal 1..3).
- CNT_W, 16, width of the performance counters.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- dec_valid  in  1  decode holds a real instruction.
- dec_rs1  in  5  decode source register 1.
- dec_rs2  in  5  decode source register 2.
- dec_rd  in  5  decode destination register.
- dec_isLoad  in  1  decode instruction is a load.
- dec_wrRd  in  1  decode instruction writes rd (0 for stores and branches).
- originPc  in  1  execute resolved a taken branch this cycle.
- stall  out  1  hold the PC and the fetch/decode pipeline register.
- bubble_e  out  1  load a NOP into the execute stage register.
- flush_d  out  1  kill the instruction currently in decode.
- fwd_rs1  out  2  source for rs1: 0 = bank, 1 = execute result, 2 = write-stage data.
- fwd_rs2  out  2  source for rs2, same encoding.
- stall_cnt  out  CNT_W  count of stall cycles, saturating.
- flush_cnt  out  CNT_W  count of flush events, saturating.

Behaviour:
- Internal slots E and W each hold {valid, rd, isLoad, wrRd}. Reset clears every slot, the FSM, the counters and all outputs to 0.
- "Match" on a source register means all of: rs != 0, slot valid, slot wrRd, slot rd == rs.
- Forwarding (combinational, per source):
  - Match on E and not E.isLoad -> 1.
  - Else match on W -> 2.
  - Else 0.
  - E has priority over W.
- Load-use hazard: dec_valid and E.isLoad and a match on rs1 or rs2 against E.
- FSM states: RUN, STALL, FLUSH. Down-counter cnt is 2 bits.
- RUN:
  - Slot update: E <= decode fields (valid = dec_valid); W <= E.
  - Taken branch (originPc = 1): assert flush_d and bubble_e the same cycle. Load E invalid, W <= E. If FLUSH_CYCLES > 1, go to FLUSH with cnt = FLUSH_CYCLES-1.
  - Load-use hazard, no branch: assert stall and bubble_e combinationally. Load E invalid, W <= E. If LOAD_STALL > 1, go to STALL with cnt = LOAD_STALL-1.
- STALL:
  - stall = 1, bubble_e = 1, E <= invalid, W <= E.
  - Decrement cnt; return to RUN when cnt reaches 0.
  - originPc during STALL: abort to flush handling exactly as in RUN. Stall is released the same cycle.
- FLUSH:
  - flush_d = 1, bubble_e = 1, stall = 0, E <= invalid, W <= E.
  - Decrement cnt; return to RUN at 0.
  - A new originPc reloads cnt = FLUSH_CYCLES-1 (FLUSH_CYCLES = 1 returns to RUN).
- Simultaneous branch and load-use: the flush wins. No stall is asserted, because the dependent instruction is squashed.
- Forwarding is evaluated every cycle, including stall cycles. After LOAD_STALL bubbles the load sits in W and forwarding yields 2.
- rd == 0 never matches, so x0 never forwards and never stalls.
- Counters:
  - stall_cnt increments in every cycle with stall = 1.
  - flush_cnt increments once per cycle with originPc = 1 that causes a flush.
  - Both saturate at all-ones and never wrap.
- Reset mid-stall or mid-flush: returns to RUN immediately with all outputs 0. The next edge after reset deasserts behaves as RUN with empty slots.

Test Plan:
- ALU back-to-back: an instruction writing rd = 5, followed by one reading rs1 = 5 -> fwd_rs1 = 1 for one cycle, then fwd_rs1 = 2 if a dependent reader follows at distance 2; stall stays 0.
- Load-use with LOAD_STALL = 1: a load to rd = 7, then a reader with rs2 = 7 -> stall = 1 and bubble_e = 1 for exactly one cycle; next cycle fwd_rs2 = 2, stall = 0; stall_cnt = 1.
- Load-use with LOAD_STALL = 3 -> stall high for 3 consecutive cycles, FSM passes through STALL, stall_cnt = 3.
- Taken branch with FLUSH_CYCLES = 2: originPc pulse -> flush_d high for 2 cycles, bubble_e high for 2 cycles, flush_cnt = 1; a load-use hazard present in the same cycle produces no stall.
- Register x0: a writer with rd = 0 followed by a reader with rs1 = 0 (including a load to x0) -> fwd_rs1 = 0, stall = 0.
- Reset asserted in the second cycle of a LOAD_STALL = 3 stall -> all outputs 0 immediately; after release the FSM is in RUN and both counters read 0; a forced 2^CNT_W+5 stall cycles leave stall_cnt at all-ones.
